// File: rtl/nibcmp_pkg.sv
// nibcmp_pkg: shared nibble width, FSM state type and index-width helper for nibble_cmp_seq
package nibcmp_pkg;

   localparam int NIB_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Index width for NNIB nibbles; a single-nibble word still needs a 1-bit index.
   function automatic int idx_w(input int nnib);
      return (nnib > 1) ? $clog2(nnib) : 1;
   endfunction

endpackage

// File: rtl/nibcmp_nib_sel.sv
// nibcmp_nib_sel: combinational extractor returning nibble i_idx (0 = bits 3:0) of a WIDTH-bit word
module nibcmp_nib_sel
   import nibcmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IW    = 2
) (
   input  logic [WIDTH-1:0] i_word,
   input  logic [IW-1:0]    i_idx,
   output logic [NIB_W-1:0] o_nib
);

   assign o_nib = i_word[i_idx*NIB_W +: NIB_W];

endmodule

// File: rtl/nibble_cmp_seq.sv
// nibble_cmp_seq: nibble-serial WIDTH-bit equality compare over one shared 4-bit slice;
// define NIBCMP_EARLY_EXIT_EN to stop the scan at the first mismatching nibble
module nibble_cmp_seq
   import nibcmp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                clr,
   input  logic [WIDTH-1:0]                    a,
   input  logic [WIDTH-1:0]                    b,
   output logic                                busy,
   output logic                                done,
   output logic                                eq,
   output logic [idx_w(WIDTH/NIB_W)-1:0]       mism_idx
);

   localparam int NNIB = WIDTH / NIB_W;
   localparam int IW   = idx_w(NNIB);
   localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_op_a, r_op_b;
   logic [IW-1:0]    r_idx, r_mism;
   logic             r_done, r_eq;
   logic [NIB_W-1:0] w_nib_a, w_nib_b;
   logic             w_nib_eq, w_last, w_accept, w_finish, w_res_eq;
   logic [IW-1:0]    w_res_idx;

   nibcmp_nib_sel #(.WIDTH(WIDTH), .IW(IW)) u_sel_a (
      .i_word (r_op_a),
      .i_idx  (r_idx),
      .o_nib  (w_nib_a)
   );

   nibcmp_nib_sel #(.WIDTH(WIDTH), .IW(IW)) u_sel_b (
      .i_word (r_op_b),
      .i_idx  (r_idx),
      .o_nib  (w_nib_b)
   );

   assign w_nib_eq = (w_nib_a == w_nib_b);
   assign w_last   = (r_idx == LAST);
   assign w_accept = (r_state == IDLE) && start && !clr;

`ifdef NIBCMP_EARLY_EXIT_EN
   assign w_finish  = !w_nib_eq || w_last;
   assign w_res_eq  = w_nib_eq;
   assign w_res_idx = w_nib_eq ? '0 : r_idx;
`else
   logic          r_sticky;
   logic [IW-1:0] r_first;

   // Remember the lowest mismatching nibble while the scan runs to the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_first  <= '0;
      end else if (w_accept || clr) begin
         r_sticky <= 1'b0;
         r_first  <= '0;
      end else if ((r_state == RUN) && !w_nib_eq && !r_sticky) begin
         r_sticky <= 1'b1;
         r_first  <= r_idx;
      end
   end

   assign w_finish  = w_last;
   assign w_res_eq  = w_nib_eq && !r_sticky;
   assign w_res_idx = r_sticky ? r_first : (w_nib_eq ? '0 : r_idx);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state: accept in IDLE, leave RUN on abort or on the final nibble result.
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE) w_next = w_accept ? RUN : IDLE;
      else                 w_next = (clr || w_finish) ? IDLE : RUN;
   end

   // Operand capture, nibble counter and registered result reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a <= '0;
         r_op_b <= '0;
         r_idx  <= '0;
         r_done <= 1'b0;
         r_eq   <= 1'b0;
         r_mism <= '0;
      end else begin
         r_done <= (r_state == RUN) && !clr && w_finish;
         if (clr) begin
            r_idx  <= '0;
            r_eq   <= 1'b0;
            r_mism <= '0;
         end else if (w_accept) begin
            r_op_a <= a;
            r_op_b <= b;
            r_idx  <= '0;
            r_eq   <= 1'b0;
            r_mism <= '0;
         end else if (r_state == RUN) begin
            if (w_finish) begin
               r_idx  <= '0;
               r_eq   <= w_res_eq;
               r_mism <= w_res_idx;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign busy     = (r_state == RUN);
   assign done     = r_done;
   assign eq       = r_eq;
   assign mism_idx = r_mism;

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// tb_nibble_cmp_seq: directed self-checking bench for nibble_cmp_seq at WIDTH=16
module tb_nibble_cmp_seq;

`ifdef NIBCMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, eq;
   logic [1:0]  mism_idx;
   int          errors = 0;
   int          checks = 0;

   nibble_cmp_seq #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .clr      (clr),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .eq       (eq),
      .mism_idx (mism_idx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_busy, input logic e_done,
                          input logic e_eq, input logic [1:0] e_idx);
      check({tag, ".busy"}, 32'(busy), 32'(e_busy));
      check({tag, ".done"}, 32'(done), 32'(e_done));
      check({tag, ".eq"}, 32'(eq), 32'(e_eq));
      check({tag, ".mism_idx"}, 32'(mism_idx), 32'(e_idx));
   endtask

   task automatic launch(input logic [15:0] va, input logic [15:0] vb);
      a = va;
      b = vb;
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("accept", 1'b1, 1'b0, 1'b0, 2'd0);
   endtask

   // Steps through E1..E(lat); done must appear exactly at E(lat).
   task automatic wait_done(input string tag, input int lat, input logic e_eq,
                            input logic [1:0] e_idx, input bit tail);
      for (int k = 1; k <= lat; k++) begin
         step();
         if (k < lat) chk_out({tag, ".run"}, 1'b1, 1'b0, 1'b0, 2'd0);
         else         chk_out({tag, ".done"}, 1'b0, 1'b1, e_eq, e_idx);
      end
      if (tail) begin
         step();
         chk_out({tag, ".hold"}, 1'b0, 1'b0, e_eq, e_idx);
      end
   endtask

   initial begin
      #12;
      chk_out("reset_asserted", 1'b0, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out("idle_no_start", 1'b0, 1'b0, 1'b0, 2'd0);
      end

      launch(16'hBEEF, 16'hBEEF);
      wait_done("full_match", 4, 1'b1, 2'd0, 1'b1);

      launch(16'h1234, 16'h1235);
      wait_done("mism_nib0", EE ? 1 : 4, 1'b0, 2'd0, 1'b1);

      launch(16'hA0F4, 16'h10F4);
      wait_done("mism_nib3", 4, 1'b0, 2'd3, 1'b1);

      launch(16'h0F0F, 16'h0000);
      wait_done("multi_mism", EE ? 1 : 4, 1'b0, 2'd0, 1'b1);

      launch(16'h1200, 16'h3400);
      wait_done("mism_nib2", EE ? 3 : 4, 1'b0, 2'd2, 1'b1);

      launch(16'hBEEF, 16'hBEEF);
      a = 16'h0000;
      step();
      chk_out("busy_ignore.e1", 1'b1, 1'b0, 1'b0, 2'd0);
      start = 1'b1;
      step();
      chk_out("busy_ignore.e2", 1'b1, 1'b0, 1'b0, 2'd0);
      start = 1'b0;
      b = 16'hFFFF;
      wait_done("busy_ignore", 2, 1'b1, 2'd0, 1'b1);
      check("busy_ignore.not_queued", 32'(busy), 32'd0);

      a = 16'hBEEF;
      b = 16'hBEEF;
      start = 1'b1;
      step();
      chk_out("b2b.accept", 1'b1, 1'b0, 1'b0, 2'd0);
      a = 16'h0001;
      b = 16'h0000;
      wait_done("b2b.first", 4, 1'b1, 2'd0, 1'b0);
      step();
      chk_out("b2b.second_accept", 1'b1, 1'b0, 1'b0, 2'd0);
      start = 1'b0;
      wait_done("b2b.second", EE ? 1 : 4, 1'b0, 2'd0, 1'b1);

      launch(16'hBEEF, 16'hBEEF);
      step();
      chk_out("clr_run.e1", 1'b1, 1'b0, 1'b0, 2'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_out("clr_run.e2", 1'b0, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out("clr_run.no_done", 1'b0, 1'b0, 1'b0, 2'd0);
      end

      launch(16'hA0F4, 16'h10F4);
      wait_done("pre_clr_idle", 4, 1'b0, 2'd3, 1'b0);
      clr = 1'b1;
      start = 1'b1;
      a = 16'h1111;
      b = 16'h1111;
      step();
      clr = 1'b0;
      start = 1'b0;
      chk_out("clr_idle_wins", 1'b0, 1'b0, 1'b0, 2'd0);
      step();
      chk_out("clr_idle_dropped", 1'b0, 1'b0, 1'b0, 2'd0);

      launch(16'hBEEF, 16'hBEEF);
      step();
      chk_out("rst_mid.e1", 1'b1, 1'b0, 1'b0, 2'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_out("rst_mid.async", 1'b0, 1'b0, 1'b0, 2'd0);
      #1 rst_n = 1'b1;
      step();
      chk_out("rst_mid.after", 1'b0, 1'b0, 1'b0, 2'd0);

      launch(16'hBEEF, 16'hBEEF);
      wait_done("post_abort", 4, 1'b1, 2'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
